// File: rtl/fir_pkg.sv
// Shared constants for the FIR datapath and its requantizer.
package fir_pkg;

  localparam int DATA_WIDTH        = 16;
  localparam int ACC_WIDTH         = 32;
  localparam int SHIFT_DEFAULT     = 15;
  localparam int CNT_WIDTH_DEFAULT = 16;

  // Largest and smallest representable DATA_WIDTH-bit two's complement values.
  localparam logic signed [DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] OUT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

endpackage

// File: rtl/fir_sat_cnt.sv
// Sticky saturation flag plus a saturating event counter; clear wins over a
// simultaneous event.
module fir_sat_cnt
  import fir_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sat_evt_i,
  input  logic                 clear_i,
  output logic                 sat_flag_o,
  output logic [CNT_WIDTH-1:0] sat_count_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                 flag_q, flag_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Next-state: clear has priority, otherwise count events and stick at all-ones.
  always_comb begin
    flag_d = flag_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      flag_d = 1'b0;
      cnt_d  = '0;
    end else if (sat_evt_i) begin
      flag_d = 1'b1;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      flag_q <= flag_d;
      cnt_q  <= cnt_d;
    end
  end

  assign sat_flag_o  = flag_q;
  assign sat_count_o = cnt_q;

endmodule

// File: rtl/fir_requant.sv
// Requantizer for the FIR accumulator: round-half-up, arithmetic shift,
// saturate to OUT_WIDTH, with saturation statistics.
// Pipeline: stage 1 holds the rounded sum, stage 2 holds the shifted and
// clamped value, the output register presents it. A sample captured at edge k
// is visible on sample_out after edge k+2.
module fir_requant
  import fir_pkg::*;
#(
  parameter int IN_WIDTH  = ACC_WIDTH,
  parameter int OUT_WIDTH = DATA_WIDTH,
  parameter int SHIFT     = SHIFT_DEFAULT,
  parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [IN_WIDTH-1:0]  sample_in,
  input  logic                        valid_in,
  input  logic                        clear_stats,
  output logic signed [OUT_WIDTH-1:0] sample_out,
  output logic                        valid_out,
  output logic                        sat_flag,
  output logic [CNT_WIDTH-1:0]        sat_count
);

  // Rounding constant is half an output LSB; zero when no shift is applied.
  localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [IN_WIDTH:0] RND =
    (SHIFT > 0) ? ({{IN_WIDTH{1'b0}}, 1'b1} << RND_POS) : '0;

  // Output limits sign-extended to the stage-1 width for direct comparison.
  localparam logic signed [IN_WIDTH:0] MAX_EXT =
    {{(IN_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [IN_WIDTH:0] MIN_EXT =
    {{(IN_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic signed [IN_WIDTH:0]    s1_d, s1_q;
  logic                        v1_q;
  logic signed [IN_WIDTH:0]    shifted;
  logic                        sat_hi, sat_lo;
  logic signed [OUT_WIDTH-1:0] s2_d, s2_q;
  logic                        v2_q, sat2_q;
  logic signed [OUT_WIDTH-1:0] out_q;
  logic                        vout_q;
  logic                        sat_evt;

  // One extra bit keeps the rounding add from overflowing.
  assign s1_d = {sample_in[IN_WIDTH-1], sample_in} + RND;

  // Stage 1: register the rounded sum; data holds while no sample arrives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q <= 1'b0;
      s1_q <= '0;
    end else begin
      v1_q <= valid_in;
      if (valid_in) begin
        s1_q <= s1_d;
      end
    end
  end

  // Shift (floor) and clamp into the output range.
  always_comb begin
    shifted = s1_q >>> SHIFT;
    sat_hi  = (shifted > MAX_EXT);
    sat_lo  = (shifted < MIN_EXT);
    s2_d    = shifted[OUT_WIDTH-1:0];
    if (sat_hi) begin
      s2_d = MAX_EXT[OUT_WIDTH-1:0];
    end else if (sat_lo) begin
      s2_d = MIN_EXT[OUT_WIDTH-1:0];
    end
  end

  // Stage 2: register the clamped value together with its saturation tag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2_q   <= 1'b0;
      s2_q   <= '0;
      sat2_q <= 1'b0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        s2_q   <= s2_d;
        sat2_q <= sat_hi | sat_lo;
      end
    end
  end

  // Output register: holds its last value through gaps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vout_q <= 1'b0;
      out_q  <= '0;
    end else begin
      vout_q <= v2_q;
      if (v2_q) begin
        out_q <= s2_q;
      end
    end
  end

  // A clamped sample counts on the edge it is emitted, so the flag rises with valid_out.
  assign sat_evt = v2_q & sat2_q;

  fir_sat_cnt #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_sat_cnt (
    .clk         (clk),
    .rst_n       (rst),
    .sat_evt_i   (sat_evt),
    .clear_i     (clear_stats),
    .sat_flag_o  (sat_flag),
    .sat_count_o (sat_count)
  );

  assign sample_out = out_q;
  assign valid_out  = vout_q;

endmodule
